alu_serial_ctrl: RTL

- Sequencer that performs a full W-bit ALU operation through one external 1-bit ALU slice, one bit per cycle, LSB first.
- Captures operands on start, drives the slice's operand, invert, carry and operation inputs each cycle, and collects its result and carry bits.
- Produces the W-bit result plus zero, carry-out and overflow flags.
- Sits between the CPU control path (ALU_control encoding) and the slice datapath.

---
 rtl/alu_serial_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs a W-bit operation through one external 1-bit ALU slice,
// LSB first, then presents the result with zero, carry-out and overflow flags.
module alu_serial_ctrl #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] src1_i,
    input  logic [W-1:0] src2_i,
    input  logic [3:0]   ALU_control_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         zero_o,
    output logic         cout_o,
    output logic         overflow_o,
    output logic         slice_a_o,
    output logic         slice_b_o,
    output logic         slice_less_o,
    output logic         slice_ainv_o,
    output logic         slice_binv_o,
    output logic         slice_cin_o,
    output logic [1:0]   slice_op_o,
    input  logic         slice_result_i,
    input  logic         slice_cout_i
);

    // state | meaning
    // IDLE  | waiting for start_i
    // RUN   | one slice bit per cycle, idx 0..W-1
    // DONE  | one-cycle done_o pulse; start_i here chains the next op
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IW = $clog2(W);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-2:0]   bits_q;
    logic [3:0]     ctrl_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;

    logic           dec_ainv;
    logic           dec_binv;
    logic [1:0]     dec_op;
    logic           run;
    logic           last;
    logic [W-1:0]   sum_full;
    logic           ovf_fin;
    logic [W-1:0]   fin_result;
    logic           fin_cout;
    logic           fin_ovf;

    always_comb begin
        dec_ainv = 1'b0;
        dec_binv = 1'b0;
        dec_op   = 2'b00;
        case (ctrl_q)
            CTL_AND: dec_op = 2'b00;
            CTL_OR:  dec_op = 2'b01;
            CTL_ADD: dec_op = 2'b10;
            CTL_SUB, CTL_SLT: begin
                dec_binv = 1'b1;
                dec_op   = 2'b10;
            end
            CTL_NOR: begin
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            default: dec_op = 2'b00;
        endcase
    end

    assign run  = (state_q == RUN);
    assign last = (idx_q == IW'(W - 1));

    assign slice_a_o    = run & a_q[idx_q];
    assign slice_b_o    = run & b_q[idx_q];
    assign slice_less_o = 1'b0;
    assign slice_ainv_o = run & dec_ainv;
    assign slice_binv_o = run & dec_binv;
    assign slice_cin_o  = run & ((idx_q == '0) ? dec_binv : carry_q);
    assign slice_op_o   = run ? dec_op : 2'b00;

    // Final values are formed from the MSB slice outputs in the last RUN cycle,
    // so the MSB carry-in never needs its own register.
    assign sum_full = {slice_result_i, bits_q};
    assign ovf_fin  = slice_cin_o ^ slice_cout_i;

    always_comb begin
        fin_result = '0;
        fin_cout   = 1'b0;
        fin_ovf    = 1'b0;
        case (ctrl_q)
            CTL_ADD, CTL_SUB: begin
                fin_result = sum_full;
                fin_cout   = slice_cout_i;
                fin_ovf    = ovf_fin;
            end
            CTL_SLT: fin_result = {{(W-1){1'b0}}, sum_full[W-1] ^ ovf_fin};
            CTL_AND, CTL_OR, CTL_NOR: fin_result = sum_full;
            default: fin_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            bits_q     <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b1;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        ctrl_q  <= ALU_control_i;
                        idx_q   <= '0;
                        carry_q <= 1'b0;
                        busy_o  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= slice_cout_i;
                    if (last) begin
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        result_o   <= fin_result;
                        zero_o     <= (fin_result == '0);
                        cout_o     <= fin_cout;
                        overflow_o <= fin_ovf;
                        state_q    <= DONE;
                    end else begin
                        bits_q[idx_q] <= slice_result_i;
                        idx_q         <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
